// File: rtl/ad5791_spi_ctrl_if.sv
// Sample/handshake and AD5791 pin bundle between the flow controller and
// the AD5791 SPI controller. The master modport is the flow-controller side.
interface ad5791_spi_ctrl_if #(
  parameter int DAC_DATA_NBIT = 20
);
  logic                     dac_start;
  logic                     dac_en;
  logic                     dac_dv;
  logic [DAC_DATA_NBIT-1:0] dac_data;
  logic                     dac_waitrequest;
  logic                     spi_sclk;
  logic                     spi_sync_n;
  logic                     spi_sdin;
  logic                     dac_ldac_n;
  logic                     busy;
  logic                     underrun;
  logic                     overrun;

  modport master (
    output dac_start, dac_en, dac_dv, dac_data,
    input  dac_waitrequest, spi_sclk, spi_sync_n, spi_sdin, dac_ldac_n,
           busy, underrun, overrun
  );

  modport slave (
    input  dac_start, dac_en, dac_dv, dac_data,
    output dac_waitrequest, spi_sclk, spi_sync_n, spi_sdin, dac_ldac_n,
           busy, underrun, overrun
  );
endinterface

// File: rtl/ad5791_spi_ctrl.sv
// AD5791 SPI write controller: buffers DAC samples in a small FIFO, writes
// the control register on enable, then sends one 24-bit DAC-register frame
// per dac_start strobe followed by an LDAC pulse.
module ad5791_spi_ctrl #(
  parameter int                       DAC_DATA_NBIT = 20,
  parameter int                       FIFO_DEPTH    = 16,
  parameter int                       SCLK_DIV      = 2,
  parameter int                       SYNC_GAP      = 4,
  parameter int                       LDAC_CYC      = 2,
  parameter logic [DAC_DATA_NBIT-1:0] CTRL_WORD     = 20'h00012
) (
  input  logic              mclk,
  input  logic              rst_n,
  ad5791_spi_ctrl_if.slave  bus
);

  localparam int FRAME_NBIT = DAC_DATA_NBIT + 4;
  localparam int PTR_W      = $clog2(FIFO_DEPTH);
  localparam int CNT_W      = PTR_W + 1;
  localparam int DIV_W      = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam int BIT_W      = $clog2(FRAME_NBIT);
  localparam int TMR_W      = 8;

  typedef enum logic [2:0] {
    ST_IDLE, ST_CFG, ST_READY, ST_SHIFT, ST_GAP, ST_LDAC
  } state_t;

  state_t                   state, state_nxt;
  logic [DAC_DATA_NBIT-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]         wr_ptr, rd_ptr;
  logic [CNT_W-1:0]         count, count_nxt;
  logic                     full, empty, push, pop, flush;
  logic                     load, load_ctrl, underrun_set, overrun_set;
  logic [FRAME_NBIT-1:0]    frame_nxt, shreg;
  logic                     sclk_q, sync_n_q, sdin_q, ldac_n_q, waitreq_q;
  logic                     underrun_q, overrun_q, is_ctrl, en_q, en_pend;
  logic [DIV_W-1:0]         div_cnt;
  logic [BIT_W-1:0]         bit_cnt;
  logic [TMR_W-1:0]         tmr;
  logic                     en_rise, stay_en, div_done, last_bit, tmr_done;

  assign full     = (count == CNT_W'(FIFO_DEPTH));
  assign empty    = (count == '0);
  assign en_rise  = bus.dac_en && !en_q;
  // An enable edge seen while busy forces a pass through IDLE so CFG reruns.
  assign stay_en  = bus.dac_en && !en_pend;
  assign div_done = (div_cnt == DIV_W'(SCLK_DIV - 1));
  assign last_bit = (bit_cnt == BIT_W'(FRAME_NBIT - 1));
  assign tmr_done = (state == ST_GAP) ? (tmr == TMR_W'(SYNC_GAP - 1))
                                      : (tmr == TMR_W'(LDAC_CYC - 1));

  // Next-state and per-cycle control strobes.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path can
    // leave it unassigned and infer a latch.
    state_nxt    = state;
    pop          = 1'b0;
    flush        = 1'b0;
    load         = 1'b0;
    load_ctrl    = 1'b0;
    underrun_set = 1'b0;
    case (state)
      ST_IDLE:  if (bus.dac_en && (en_rise || en_pend)) state_nxt = ST_CFG;
      ST_CFG: begin
        load      = 1'b1;
        load_ctrl = 1'b1;
        state_nxt = ST_SHIFT;
      end
      ST_READY: begin
        if (!bus.dac_en) begin
          flush     = 1'b1;
          state_nxt = ST_IDLE;
        end else if (bus.dac_start) begin
          if (empty) begin
            underrun_set = 1'b1;
          end else begin
            pop       = 1'b1;
            load      = 1'b1;
            state_nxt = ST_SHIFT;
          end
        end
      end
      ST_SHIFT: if (div_done && !sclk_q && last_bit) state_nxt = ST_GAP;
      ST_GAP: begin
        if (tmr_done) begin
          if (!is_ctrl)     state_nxt = ST_LDAC;
          else if (stay_en) state_nxt = ST_READY;
          else begin
            flush     = 1'b1;
            state_nxt = ST_IDLE;
          end
        end
      end
      ST_LDAC: begin
        if (tmr_done) begin
          if (stay_en) state_nxt = ST_READY;
          else begin
            flush     = 1'b1;
            state_nxt = ST_IDLE;
          end
        end
      end
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // A write is accepted when there is room, or when a pop frees a slot this cycle.
  assign push        = bus.dac_dv && (!full || pop) && !flush;
  assign overrun_set = bus.dac_dv && full && !pop;
  assign count_nxt   = flush ? '0 : count + CNT_W'(push) - CNT_W'(pop);
  assign frame_nxt   = load_ctrl ? {1'b0, 3'b010, CTRL_WORD}
                                 : {1'b0, 3'b001, mem[rd_ptr]};

  // State register.
  always_ff @(posedge mclk) begin
    // NOTE: registers take non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Sample storage.
  always_ff @(posedge mclk) begin
    // NOTE: the array has no reset; pointers and count define validity.
    if (push) mem[wr_ptr] <= bus.dac_data;
  end

  // FIFO pointers, occupancy and back-pressure.
  always_ff @(posedge mclk) begin
    if (!rst_n || flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      waitreq_q <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count     <= count_nxt;
      waitreq_q <= (count_nxt == CNT_W'(FIFO_DEPTH));
    end
  end

  // Serialiser, gap/LDAC timer, enable-edge tracking and sticky flags.
  always_ff @(posedge mclk) begin
    if (!rst_n) begin
      sclk_q     <= 1'b1;
      sync_n_q   <= 1'b1;
      sdin_q     <= 1'b0;
      ldac_n_q   <= 1'b1;
      shreg      <= '0;
      is_ctrl    <= 1'b0;
      div_cnt    <= '0;
      bit_cnt    <= '0;
      tmr        <= '0;
      en_q       <= 1'b0;
      en_pend    <= 1'b0;
      underrun_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      en_q <= bus.dac_en;
      if (state == ST_IDLE) en_pend <= 1'b0;
      else if (en_rise)     en_pend <= 1'b1;
      if (underrun_set) underrun_q <= 1'b1;
      if (overrun_set)  overrun_q  <= 1'b1;

      if (load) begin
        shreg    <= frame_nxt;
        sdin_q   <= frame_nxt[FRAME_NBIT-1];
        sync_n_q <= 1'b0;
        sclk_q   <= 1'b1;
        div_cnt  <= '0;
        bit_cnt  <= '0;
        is_ctrl  <= load_ctrl;
      end else if (state == ST_SHIFT) begin
        if (!div_done) begin
          div_cnt <= div_cnt + DIV_W'(1);
        end else begin
          div_cnt <= '0;
          if (sclk_q) begin
            sclk_q <= 1'b0;
          end else if (last_bit) begin
            sclk_q   <= 1'b1;
            sync_n_q <= 1'b1;
            tmr      <= '0;
          end else begin
            sclk_q  <= 1'b1;
            shreg   <= {shreg[FRAME_NBIT-2:0], 1'b0};
            sdin_q  <= shreg[FRAME_NBIT-2];
            bit_cnt <= bit_cnt + BIT_W'(1);
          end
        end
      end else if (state == ST_GAP || state == ST_LDAC) begin
        tmr <= tmr_done ? '0 : tmr + TMR_W'(1);
        if (state == ST_GAP && tmr_done && !is_ctrl) ldac_n_q <= 1'b0;
        if (state == ST_LDAC && tmr_done)            ldac_n_q <= 1'b1;
      end
    end
  end

  assign bus.dac_waitrequest = waitreq_q;
  assign bus.spi_sclk        = sclk_q;
  assign bus.spi_sync_n      = sync_n_q;
  assign bus.spi_sdin        = sdin_q;
  assign bus.dac_ldac_n      = ldac_n_q;
  assign bus.busy            = (state != ST_IDLE) && (state != ST_READY);
  assign bus.underrun        = underrun_q;
  assign bus.overrun         = overrun_q;

endmodule

// File: tb/tb_ad5791_spi_ctrl.sv
// Self-checking bench for ad5791_spi_ctrl: a pin-level monitor decodes SPI
// frames and LDAC pulses; a queue model predicts FIFO contents and flags.
module tb_ad5791_spi_ctrl;
  localparam int NB    = 20;
  localparam int DEPTH = 16;

  logic mclk;
  logic rst_n;

  initial begin
    mclk = 1'b0;
    forever #5 mclk = ~mclk;
  end

  ad5791_spi_ctrl_if #(.DAC_DATA_NBIT(NB)) bus ();

  ad5791_spi_ctrl #(
    .DAC_DATA_NBIT(NB), .FIFO_DEPTH(DEPTH), .SCLK_DIV(2),
    .SYNC_GAP(4), .LDAC_CYC(2), .CTRL_WORD(20'h00012)
  ) dut (
    .mclk  (mclk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_err    = 0;

  logic [NB-1:0] model_q[$];

  // Pin-level observations.
  int          frame_cnt = 0, frame_bits = 0, sync_len = 0, last_rise = 0;
  int          ldac_cnt = 0, ldac_len = 0, ldac_delay = 0, cyc = 0;
  logic [23:0] frame_val = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge mclk);
  endtask

  // Decode SYNC/SCLK/SDIN frames and LDAC pulses, sampling mid-cycle.
  initial begin
    logic        prev_sclk, prev_sync, prev_ldac;
    logic [23:0] cur_sh;
    int          cur_bits, cur_len, cur_ldac;
    prev_sclk = 1'b1; prev_sync = 1'b1; prev_ldac = 1'b1;
    cur_sh = '0; cur_bits = 0; cur_len = 0; cur_ldac = 0;
    forever begin
      @(negedge mclk);
      cyc++;
      if (!bus.spi_sync_n) begin
        if (prev_sync) begin
          cur_sh = '0; cur_bits = 0; cur_len = 0;
        end
        cur_len++;
        if (prev_sclk && !bus.spi_sclk) begin
          cur_sh = {cur_sh[22:0], bus.spi_sdin};
          cur_bits++;
        end
      end else if (!prev_sync) begin
        frame_val  = cur_sh;
        frame_bits = cur_bits;
        sync_len   = cur_len;
        last_rise  = cyc;
        frame_cnt++;
      end
      if (!bus.dac_ldac_n) begin
        if (prev_ldac) begin
          cur_ldac   = 0;
          ldac_delay = cyc - last_rise;
        end
        cur_ldac++;
      end else if (!prev_ldac) begin
        ldac_len = cur_ldac;
        ldac_cnt++;
      end
      prev_sclk = bus.spi_sclk;
      prev_sync = bus.spi_sync_n;
      prev_ldac = bus.dac_ldac_n;
    end
  end

  task automatic push(input logic [NB-1:0] d);
    bus.dac_dv   = 1'b1;
    bus.dac_data = d;
    if (model_q.size() < DEPTH) model_q.push_back(d);
    tick();
    bus.dac_dv = 1'b0;
  endtask

  task automatic strobe_start();
    bus.dac_start = 1'b1;
    tick();
    bus.dac_start = 1'b0;
  endtask

  task automatic wait_frame(input int n0, input logic [23:0] exp, input string tag);
    int k = 0;
    while (frame_cnt == n0 && k < 2000) begin
      tick();
      k++;
    end
    check({tag, "_seen"}, 32'(frame_cnt != n0), 32'd1);
    if (frame_cnt != n0) begin
      check({tag, "_frame"}, 32'(frame_val), 32'(exp));
      check({tag, "_bits"}, frame_bits, 24);
      check({tag, "_sync_len"}, sync_len, 96);
    end
  endtask

  task automatic wait_ldac(input int l0, input string tag);
    int k = 0;
    while (ldac_cnt == l0 && k < 200) begin
      tick();
      k++;
    end
    check({tag, "_ldac_seen"}, 32'(ldac_cnt != l0), 32'd1);
    if (ldac_cnt != l0) begin
      check({tag, "_ldac_len"}, ldac_len, 2);
      check({tag, "_ldac_delay"}, ldac_delay, 4);
    end
  endtask

  // Data frame = write to DAC register (address 001) carrying the sample.
  task automatic send_one(input string tag);
    logic [23:0] exp;
    int n0, l0;
    exp = 24'h100000 | 24'(model_q.pop_front());
    n0  = frame_cnt;
    l0  = ldac_cnt;
    strobe_start();
    wait_frame(n0, exp, tag);
    wait_ldac(l0, tag);
  endtask

  task automatic do_config();
    int n0, l0;
    n0 = frame_cnt;
    l0 = ldac_cnt;
    bus.dac_en = 1'b1;
    tick();
    wait_frame(n0, 24'h200012, "cfg");
    repeat (20) tick();
    check("cfg_no_ldac", ldac_cnt, l0);
    check("cfg_busy", bus.busy, 1'b0);
  endtask

  initial begin
    logic [NB-1:0] x;
    logic [23:0]   exp;
    int            n0, l0;

    rst_n = 1'b0;
    bus.dac_start = 1'b0; bus.dac_en = 1'b0; bus.dac_dv = 1'b0; bus.dac_data = '0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    check("rst_sync_n", bus.spi_sync_n, 1'b1);
    check("rst_sclk", bus.spi_sclk, 1'b1);
    check("rst_sdin", bus.spi_sdin, 1'b0);
    check("rst_ldac_n", bus.dac_ldac_n, 1'b1);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_unf", bus.underrun, 1'b0);
    check("rst_ovr", bus.overrun, 1'b0);
    check("rst_wreq", bus.dac_waitrequest, 1'b0);

    do_config();

    push(20'hABCDE);
    send_one("abcde");
    for (int i = 0; i < 3; i++) begin
      push(NB'($urandom));
      send_one("rand");
    end

    // Fill to full, then pop and push in the same cycle.
    for (int i = 0; i < DEPTH - 1; i++) push(NB'($urandom));
    check("wreq_15", bus.dac_waitrequest, 1'b0);
    push(NB'($urandom));
    check("wreq_16", bus.dac_waitrequest, 1'b1);
    x   = NB'($urandom);
    exp = 24'h100000 | 24'(model_q.pop_front());
    model_q.push_back(x);
    n0 = frame_cnt; l0 = ldac_cnt;
    bus.dac_start = 1'b1; bus.dac_dv = 1'b1; bus.dac_data = x;
    tick();
    bus.dac_start = 1'b0; bus.dac_dv = 1'b0;
    wait_frame(n0, exp, "full_rw");
    wait_ldac(l0, "full_rw");
    check("full_rw_wreq", bus.dac_waitrequest, 1'b1);
    check("full_rw_ovr", bus.overrun, 1'b0);
    push(NB'($urandom));
    check("ovr_set", bus.overrun, 1'b1);
    check("ovr_wreq", bus.dac_waitrequest, 1'b1);
    while (model_q.size() > 0) send_one("drain");
    check("drain_wreq", bus.dac_waitrequest, 1'b0);

    // Disable mid-frame with samples queued.
    for (int i = 0; i < 4; i++) push(NB'($urandom));
    exp = 24'h100000 | 24'(model_q.pop_front());
    n0 = frame_cnt; l0 = ldac_cnt;
    strobe_start();
    repeat (20) tick();
    bus.dac_en = 1'b0;
    wait_frame(n0, exp, "dis");
    wait_ldac(l0, "dis");
    repeat (3) tick();
    check("dis_busy", bus.busy, 1'b0);
    model_q.delete();
    n0 = frame_cnt;
    strobe_start();
    repeat (10) tick();
    check("idle_start_unf", bus.underrun, 1'b0);
    check("idle_start_noframe", frame_cnt, n0);
    do_config();

    // Underrun: flushed FIFO is empty on return to READY.
    n0 = frame_cnt;
    strobe_start();
    check("unf_set", bus.underrun, 1'b1);
    repeat (10) tick();
    check("unf_noframe", frame_cnt, n0);
    check("unf_sync_n", bus.spi_sync_n, 1'b1);
    check("unf_busy", bus.busy, 1'b0);

    // Reset in the middle of a frame.
    push(NB'($urandom));
    push(NB'($urandom));
    strobe_start();
    repeat (30) tick();
    bus.dac_en = 1'b0;
    rst_n = 1'b0;
    tick();
    check("mrst_sync_n", bus.spi_sync_n, 1'b1);
    check("mrst_sclk", bus.spi_sclk, 1'b1);
    check("mrst_ldac_n", bus.dac_ldac_n, 1'b1);
    check("mrst_unf", bus.underrun, 1'b0);
    check("mrst_ovr", bus.overrun, 1'b0);
    check("mrst_wreq", bus.dac_waitrequest, 1'b0);
    check("mrst_busy", bus.busy, 1'b0);
    rst_n = 1'b1;
    model_q.delete();
    tick();
    do_config();
    n0 = frame_cnt;
    strobe_start();
    check("mrst_empty_unf", bus.underrun, 1'b1);
    repeat (10) tick();
    check("mrst_empty_noframe", frame_cnt, n0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
